// File: rtl/starflux_pkg.sv
// Shared types and constants for the starflux video datapath.
// Arbiter state, pixel lane widths and screen geometry.
package starflux_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  localparam int DEF_X_W   = 8;
  localparam int DEF_Y_W   = 7;
  localparam int DEF_COL_W = 3;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select.
// Scans i_req from i_ptr upward, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    w_j      = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!o_found && i_req[w_j]) begin
        o_found       = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin owner of the VGA framebuffer write port.
// Bursts run under one-hot grant; a watchdog frees a stuck owner.
module vga_write_arbiter
  import starflux_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int COL_W     = DEF_COL_W,
  parameter int MAX_BURST = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       pix_valid,
  input  logic [NUM_REQ-1:0]       pix_last,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*COL_W-1:0] req_col,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST);

  arb_state_t         r_state, w_state_nxt;
  logic [IW-1:0]      r_ptr, w_ptr_nxt;
  logic [IW-1:0]      r_owner, w_owner_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [X_W-1:0]     r_x, w_x_nxt;
  logic [Y_W-1:0]     r_y, w_y_nxt;
  logic [COL_W-1:0]   r_col, w_col_nxt;
  logic               r_plot, w_plot_nxt;
  logic               r_tmo, w_tmo_nxt;

  logic [NUM_REQ-1:0] w_win;
  logic [IW-1:0]      w_win_idx;
  logic               w_found;

  logic               w_own_valid;
  logic               w_own_last;
  logic [X_W-1:0]     w_own_x;
  logic [Y_W-1:0]     w_own_y;
  logic [COL_W-1:0]   w_own_col;
  logic               w_cnt_done;
  logic [IW-1:0]      w_ptr_inc;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win),
    .o_idx    (w_win_idx),
    .o_found  (w_found)
  );

  assign w_own_valid = pix_valid[r_owner];
  assign w_own_last  = w_own_valid & pix_last[r_owner];
  assign w_own_x     = req_x[r_owner*X_W +: X_W];
  assign w_own_y     = req_y[r_owner*Y_W +: Y_W];
  assign w_own_col   = req_col[r_owner*COL_W +: COL_W];
  assign w_cnt_done  = (r_cnt == CW'(MAX_BURST - 1));
  assign w_ptr_inc   = (r_owner == IW'(NUM_REQ - 1)) ?
                       '0 : r_owner + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_col_nxt   = r_col;
    w_plot_nxt  = 1'b0;
    w_tmo_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable && w_found) begin
          w_state_nxt = BURST;
          w_gnt_nxt   = w_win;
          w_owner_nxt = w_win_idx;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (w_own_valid) begin
          w_x_nxt    = w_own_x;
          w_y_nxt    = w_own_y;
          w_col_nxt  = w_own_col;
          w_plot_nxt = 1'b1;
        end
        // A real last pixel wins over the watchdog on the same cycle
        if (w_own_last || w_cnt_done) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_ptr_inc;
          w_tmo_nxt   = ~w_own_last;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_col   <= '0;
      r_plot  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_col   <= w_col_nxt;
      r_plot  <= w_plot_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_col;
  assign vga_plot   = r_plot;
  assign busy       = (r_state == BURST);
  assign timeout    = r_tmo;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter.
// Watchdog scenarios use a 16-cycle burst limit.
module tb_vga_write_arbiter;

  localparam int NR = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [NR-1:0]   req;
  logic [NR-1:0]   pix_valid;
  logic [NR-1:0]   pix_last;
  logic [NR*XW-1:0] req_x;
  logic [NR*YW-1:0] req_y;
  logic [NR*CW-1:0] req_col;
  logic [NR-1:0]   gnt;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot;
  logic            busy;
  logic            timeout;

  int n_vec = 0;
  int n_err = 0;

  vga_write_arbiter #(
    .NUM_REQ   (NR),
    .X_W       (XW),
    .Y_W       (YW),
    .COL_W     (CW),
    .MAX_BURST (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req        (req),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_col    (req_col),
    .gnt        (gnt),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_lanes();
    pix_valid = '0;
    pix_last  = '0;
    req_x     = '0;
    req_y     = '0;
    req_col   = '0;
  endtask

  task automatic drive(input int i, input bit v, input bit l,
                       input int x, input int y, input int c);
    pix_valid[i] = v;
    pix_last[i]  = l;
    req_x[i*XW +: XW] = XW'(x);
    req_y[i*YW +: YW] = YW'(y);
    req_col[i*CW +: CW] = CW'(c);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    req    = '0;
    clr_lanes();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({gnt, vga_plot, busy, timeout} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got gnt=%b plot=%b busy=%b tmo=%b want all 0",
               gnt, vga_plot, busy, timeout);
    end
    n_vec++;
    if ({vga_x, vga_y, vga_colour} !== 18'b0) begin
      n_err++;
      $display("FAIL reset_pix: got x=%0d y=%0d c=%0d want 0,0,0",
               vga_x, vga_y, vga_colour);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    enable = 1'b1;
    tick();
    n_vec++;
    if (gnt !== 4'b0010 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_gnt: got gnt=%b busy=%b want 0010 1", gnt, busy);
    end
    for (int p = 0; p < 3; p++) begin
      drive(1, 1'b1, p == 2, 10 + p, 20, 5);
      tick();
      n_vec++;
      if (vga_plot !== 1'b1 || vga_x !== XW'(10 + p) ||
          vga_y !== 7'd20 || vga_colour !== 3'd5) begin
        n_err++;
        $display("FAIL single_pix%0d: got plot=%b (%0d,%0d,%0d) want 1 (%0d,20,5)",
                 p, vga_plot, vga_x, vga_y, vga_colour, 10 + p);
      end
    end
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_rel: got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    req = '0;
    clr_lanes();
    tick();
    n_vec++;
    if (vga_plot !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle_plot: got %b want 0", vga_plot);
    end
  endtask

  task automatic test_contention();
    int e;
    do_reset();
    req = 4'b1111;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      tick();
      n_vec++;
      if (gnt !== 4'(1 << e) || vga_plot !== 1'b0) begin
        n_err++;
        $display("FAIL cont_gnt%0d: got gnt=%b plot=%b want %b 0",
                 k, gnt, vga_plot, 4'(1 << e));
      end
      for (int p = 1; p <= 2; p++) begin
        for (int i = 0; i < NR; i++) drive(i, 1'b1, p == 2, i*10 + p, i, i);
        tick();
        n_vec++;
        if (vga_plot !== 1'b1 || vga_x !== XW'(e*10 + p) ||
            vga_y !== YW'(e)) begin
          n_err++;
          $display("FAIL cont_pix%0d_%0d: got plot=%b (%0d,%0d) want 1 (%0d,%0d)",
                   k, p, vga_plot, vga_x, vga_y, e*10 + p, e);
        end
      end
      n_vec++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL cont_rel%0d: got gnt=%b busy=%b want 0000 0",
                 k, gnt, busy);
      end
      clr_lanes();
    end
    req = '0;
    tick();
  endtask

  task automatic test_gating();
    do_reset();
    req = 4'b0100;
    enable = 1'b0;
    tick();
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL gate_off: got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    enable = 1'b1;
    tick();
    n_vec++;
    if (gnt !== 4'b0100) begin
      n_err++;
      $display("FAIL gate_on: got gnt=%b want 0100", gnt);
    end
    enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drive(2, 1'b1, p == 2, 30 + p, 40, 2);
      tick();
      n_vec++;
      if (vga_plot !== 1'b1 || vga_x !== XW'(30 + p)) begin
        n_err++;
        $display("FAIL gate_burst%0d: got plot=%b x=%0d want 1 %0d",
                 p, vga_plot, vga_x, 30 + p);
      end
    end
    clr_lanes();
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL gate_after: got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    req = '0;
  endtask

  task automatic test_foreign();
    do_reset();
    req = 4'b0010;
    enable = 1'b1;
    tick();
    req = '0;
    drive(3, 1'b1, 1'b0, 99, 99, 7);
    tick();
    n_vec++;
    if (vga_plot !== 1'b0 || gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL foreign_drop: got plot=%b x=%0d gnt=%b want 0 - 0010",
               vga_plot, vga_x, gnt);
    end
    drive(3, 1'b1, 1'b1, 99, 99, 7);
    drive(1, 1'b1, 1'b1, 5, 6, 1);
    tick();
    n_vec++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd5 || vga_y !== 7'd6 ||
        vga_colour !== 3'd1) begin
      n_err++;
      $display("FAIL foreign_own: got plot=%b (%0d,%0d,%0d) want 1 (5,6,1)",
               vga_plot, vga_x, vga_y, vga_colour);
    end
    clr_lanes();
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    req = 4'b0010;
    enable = 1'b1;
    tick();
    for (int c = 1; c < 16; c++) tick();
    n_vec++;
    if (gnt !== 4'b0010 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL wd_hold: got gnt=%b tmo=%b want 0010 0", gnt, timeout);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL wd_fire: got gnt=%b tmo=%b busy=%b want 0000 1 0",
               gnt, timeout, busy);
    end
    req = 4'b0110;
    tick();
    n_vec++;
    if (timeout !== 1'b0 || gnt !== 4'b0100) begin
      n_err++;
      $display("FAIL wd_ptr: got tmo=%b gnt=%b want 0 0100", timeout, gnt);
    end
    req = '0;
    drive(2, 1'b1, 1'b1, 1, 1, 1);
    tick();
    clr_lanes();
    do_reset();
    req = 4'b0001;
    enable = 1'b1;
    tick();
    req = '0;
    for (int c = 1; c < 16; c++) tick();
    drive(0, 1'b1, 1'b1, 7, 8, 3);
    tick();
    n_vec++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd7 || timeout !== 1'b0 ||
        gnt !== 4'b0000) begin
      n_err++;
      $display("FAIL wd_last_tie: got plot=%b x=%0d tmo=%b gnt=%b want 1 7 0 0000",
               vga_plot, vga_x, timeout, gnt);
    end
    clr_lanes();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    enable = 1'b1;
    tick();
    drive(2, 1'b1, 1'b0, 50, 51, 4);
    tick();
    n_vec++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd50) begin
      n_err++;
      $display("FAIL rmid_pix1: got plot=%b x=%0d want 1 50", vga_plot, vga_x);
    end
    drive(2, 1'b1, 1'b0, 52, 51, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (gnt !== 4'b0000 || vga_plot !== 1'b0 || busy !== 1'b0 ||
        vga_x !== 8'd0) begin
      n_err++;
      $display("FAIL rmid_reset: got gnt=%b plot=%b busy=%b x=%0d want 0000 0 0 0",
               gnt, vga_plot, busy, vga_x);
    end
    clr_lanes();
    req = 4'b1111;
    tick();
    n_vec++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL rmid_next: got gnt=%b want 0001", gnt);
    end
    req = '0;
    drive(0, 1'b1, 1'b1, 1, 1, 1);
    tick();
    clr_lanes();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_gating();
    test_foreign();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL time_limit: got no completion want completion");
    $fatal(1, "time limit");
  end

endmodule
